mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 30 +++
 rtl/mem_tag_owner_table.sv | 61 ++++++
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: bus command encoding, arbiter
// state encoding, completion-tag owner encoding and the tag width.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_D = 2'd1,
    ARB_HOLD_I = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_DC = 1'b0,
    OWN_IC = 1'b1
  } owner_e;

  // Memory tags and responses are 4 bits wide on the bus.
  localparam int unsigned TAG_W = 4;

  // The requester that is not `o`.
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_DC) ? OWN_IC : OWN_DC;
  endfunction

endpackage

// File: rtl/mem_tag_owner_table.sv
// Completion-tag owner table: one valid bit and one owner bit per memory tag.
// Records on an accepted load, clears on a completion; when both hit the same
// tag in one cycle the record wins. Lookup is combinational.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rec_en,
  input  logic [TAG_W-1:0] rec_tag,
  input  owner_e           rec_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output owner_e           lookup_owner
);

  logic [NUM_TAGS-1:0] valid_q;
  owner_e              owner_q [NUM_TAGS];

  logic rec_in_range;
  logic clr_in_range;
  logic lookup_in_range;

  assign rec_in_range    = 32'(rec_tag)    < NUM_TAGS;
  assign clr_in_range    = 32'(clr_tag)    < NUM_TAGS;
  assign lookup_in_range = 32'(lookup_tag) < NUM_TAGS;

  // Valid bits: clear on completion, then set on record so the record wins.
  // NOTE: sequential state uses non-blocking assignments; with two NBAs to the
  // same bit in one block, the later one (the set) takes effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (clr_en && clr_in_range) valid_q[clr_tag] <= 1'b0;
      if (rec_en && rec_in_range) valid_q[rec_tag] <= 1'b1;
    end
  end

  // Owner bits: written on record only.
  // NOTE: the owner array has no reset; it is only ever read qualified by its
  // valid bit, so resetting it would buy nothing.
  always_ff @(posedge clock) begin
    if (rec_en && rec_in_range) owner_q[rec_tag] <= rec_owner;
  end

  // Combinational lookup of the completing tag.
  always_comb begin
    lookup_valid = 1'b0;
    lookup_owner = OWN_DC;
    if (lookup_in_range) begin
      lookup_valid = valid_q[lookup_tag];
      lookup_owner = owner_q[lookup_tag];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (dcache/icache) memory bus arbiter with retry lock and
// completion-tag routing.
// Optional: define MEM_ARB_ROUND_ROBIN_EN to break IDLE ties round-robin
// instead of fixed dcache priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_TAGS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  bus_command_e      dc_command,
  input  logic [63:0]       dc_addr,
  input  logic [DATA_W-1:0] dc_data,
  input  bus_command_e      ic_command,
  input  logic [63:0]       ic_addr,
  input  logic [3:0]        Dmem2proc_response,
  input  logic [3:0]        Dmem2proc_tag,
  input  logic [DATA_W-1:0] Dmem2proc_data,
  output bus_command_e      proc2mem_command,
  output logic [63:0]       proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  output logic [3:0]        dc_response,
  output logic [3:0]        dc_tag,
  output logic [3:0]        ic_response,
  output logic [3:0]        ic_tag,
  output logic [DATA_W-1:0] dc_rdata,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              orphan_tag
);

  localparam logic [1:0] IDLE   = ARB_IDLE;
  localparam logic [1:0] HOLD_D = ARB_HOLD_D;
  localparam logic [1:0] HOLD_I = ARB_HOLD_I;

  logic [1:0]        state_q, state_d;
  logic              dc_req, ic_req;
  logic              grant_dc, grant_ic, granted;
  logic              resp_nz, accepted;
  owner_e            grant_owner;
  bus_command_e      issue_cmd;
  logic [63:0]       issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic              tie_to_dc;
  logic              comp_nz, rec_en, clr_en, lookup_valid;
  owner_e            lookup_owner;

  assign dc_req      = dc_command != BUS_NONE;
  assign ic_req      = ic_command != BUS_NONE;
  assign granted     = grant_dc | grant_ic;
  assign resp_nz     = Dmem2proc_response != 4'd0;
  assign accepted    = granted & resp_nz;
  assign grant_owner = grant_ic ? OWN_IC : OWN_DC;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // prio_q names the requester favoured on the next tie, i.e. the one not
  // granted last; it starts on dcache.
  owner_e prio_q, prio_d;

  assign prio_d    = accepted ? other_owner(grant_owner) : prio_q;
  assign tie_to_dc = prio_q == OWN_DC;

  // Tie-break pointer, advanced on every accepted issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prio_q <= OWN_DC;
    else        prio_q <= prio_d;
  end
`else
  assign tie_to_dc = 1'b1;
`endif

  // Grant: pick a winner in IDLE, stay locked to the held requester otherwise.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc_req && ic_req) begin
          grant_dc = tie_to_dc;
          grant_ic = !tie_to_dc;
        end else begin
          grant_dc = dc_req;
          grant_ic = ic_req;
        end
      end
      HOLD_D:  grant_dc = dc_req;
      HOLD_I:  grant_ic = ic_req;
      default: ;
    endcase
  end

  // Bus mux: the granted requester's command, or an all-zero idle bus.
  always_comb begin
    issue_cmd  = BUS_NONE;
    issue_addr = '0;
    issue_data = '0;
    if (grant_dc) begin
      issue_cmd  = dc_command;
      issue_addr = dc_addr;
      issue_data = dc_data;
    end else if (grant_ic) begin
      issue_cmd  = ic_command;
      issue_addr = ic_addr;
    end
  end

  // Next state: a rejected issue locks the bus to its requester; anything
  // else (acceptance, drop, no request) goes back to IDLE.
  always_comb begin
    state_d = IDLE;
    if (grant_dc && !resp_nz)      state_d = HOLD_D;
    else if (grant_ic && !resp_nz) state_d = HOLD_I;
  end

  // Arbiter state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign comp_nz = Dmem2proc_tag != 4'd0;
  assign rec_en  = accepted && (issue_cmd == BUS_LOAD);
  assign clr_en  = comp_nz && lookup_valid;

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .rec_en       (rec_en),
    .rec_tag      (Dmem2proc_response),
    .rec_owner    (grant_owner),
    .clr_en       (clr_en),
    .clr_tag      (Dmem2proc_tag),
    .lookup_tag   (Dmem2proc_tag),
    .lookup_valid (lookup_valid),
    .lookup_owner (lookup_owner)
  );

  // Output drive: everything is forced to zero while reset is held low,
  // independent of the clock.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    dc_response      = '0;
    ic_response      = '0;
    dc_tag           = '0;
    ic_tag           = '0;
    dc_rdata         = '0;
    ic_rdata         = '0;
    orphan_tag       = 1'b0;
    if (reset) begin
      proc2mem_command = issue_cmd;
      proc2mem_addr    = issue_addr;
      proc2mem_data    = issue_data;
      if (grant_dc) dc_response = Dmem2proc_response;
      if (grant_ic) ic_response = Dmem2proc_response;
      if (comp_nz) begin
        if (!lookup_valid) begin
          orphan_tag = 1'b1;
        end else if (lookup_owner == OWN_DC) begin
          dc_tag   = Dmem2proc_tag;
          dc_rdata = Dmem2proc_data;
        end else begin
          ic_tag   = Dmem2proc_tag;
          ic_rdata = Dmem2proc_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset behaviour, a vector table of
// single-cycle arbitration cases, hand-written multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic         clock;
  logic         reset;
  bus_command_e dc_command, ic_command, proc2mem_command;
  logic [63:0]  dc_addr, ic_addr, proc2mem_addr;
  logic [63:0]  dc_data, Dmem2proc_data, proc2mem_data, dc_rdata, ic_rdata;
  logic [3:0]   Dmem2proc_response, Dmem2proc_tag;
  logic [3:0]   dc_response, dc_tag, ic_response, ic_tag;
  logic         orphan_tag;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.DATA_W(64), .NUM_TAGS(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .dc_command         (dc_command),
    .dc_addr            (dc_addr),
    .dc_data            (dc_data),
    .ic_command         (ic_command),
    .ic_addr            (ic_addr),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_tag      (Dmem2proc_tag),
    .Dmem2proc_data     (Dmem2proc_data),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .dc_response        (dc_response),
    .dc_tag             (dc_tag),
    .ic_response        (ic_response),
    .ic_tag             (ic_tag),
    .dc_rdata           (dc_rdata),
    .ic_rdata           (ic_rdata),
    .orphan_tag         (orphan_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bus_command_e dc_cmd;
    logic [63:0]  dc_a;
    logic [63:0]  dc_d;
    bus_command_e ic_cmd;
    logic [63:0]  ic_a;
    logic [3:0]   rsp;
    bus_command_e e_cmd;
    logic [63:0]  e_addr;
    logic [63:0]  e_data;
    logic [3:0]   e_dcr;
    logic [3:0]   e_icr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 later.
  task automatic drive(input bus_command_e dcc, input logic [63:0] dca, input logic [63:0] dcd,
                       input bus_command_e icc, input logic [63:0] ica, input logic [3:0] rsp,
                       input logic [3:0] tg, input logic [63:0] rd);
    dc_command = dcc; dc_addr = dca; dc_data = dcd;
    ic_command = icc; ic_addr = ica;
    Dmem2proc_response = rsp; Dmem2proc_tag = tg; Dmem2proc_data = rd;
    #3;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bus(input string n, input bus_command_e c, input logic [63:0] a,
                           input logic [63:0] d, input logic [3:0] dr, input logic [3:0] ir);
    check({n, ".cmd"},     64'(proc2mem_command), 64'(c));
    check({n, ".addr"},    proc2mem_addr, a);
    check({n, ".data"},    proc2mem_data, d);
    check({n, ".dc_resp"}, 64'(dc_response), 64'(dr));
    check({n, ".ic_resp"}, 64'(ic_response), 64'(ir));
  endtask

  task automatic check_ret(input string n, input logic [3:0] dt, input logic [63:0] dd,
                           input logic [3:0] it, input logic [63:0] id, input logic orph);
    check({n, ".dc_tag"},   64'(dc_tag), 64'(dt));
    check({n, ".dc_rdata"}, dc_rdata, dd);
    check({n, ".ic_tag"},   64'(ic_tag), 64'(it));
    check({n, ".ic_rdata"}, ic_rdata, id);
    check({n, ".orphan"},   64'(orphan_tag), 64'(orph));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Reference model state: owner per tag (-1 none, 0 dc, 1 ic), requester the
  // bus is locked to after a rejection, and the requester favoured on a tie.
  int owner_tab [16];
  int locked;
  int favour;

  initial begin
    // ---------------- reset state: outputs zero with live inputs
    reset = 1'b0;
    drive(BUS_LOAD, 64'h100, 64'hAA, BUS_LOAD, 64'h200, 4'd3, 4'd5, 64'hDEAD);
    check_bus("rst", BUS_NONE, 0, 0, 0, 0);
    check_ret("rst", 0, 0, 0, 0, 1'b0);
    do_reset();

    // ---------------- single-cycle arbitration vectors
    vecs[0] = '{BUS_NONE,  64'h0,    64'h0,    BUS_NONE, 64'h0,    4'd0,  BUS_NONE,  64'h0,    64'h0,    4'd0,  4'd0};
    vecs[1] = '{BUS_STORE, 64'h1000, 64'h1111_2222_3333_4444, BUS_NONE, 64'h0, 4'd3,
                BUS_STORE, 64'h1000, 64'h1111_2222_3333_4444, 4'd3, 4'd0};
    vecs[2] = '{BUS_NONE,  64'h0,    64'h0,    BUS_LOAD, 64'h2000, 4'd5,  BUS_LOAD,  64'h2000, 64'h0,    4'd0,  4'd5};
    vecs[3] = '{BUS_STORE, 64'h3000, 64'h55,   BUS_LOAD, 64'h3100, 4'd2,  BUS_STORE, 64'h3000, 64'h55,   4'd2,  4'd0};
    vecs[4] = '{BUS_NONE,  64'h0,    64'h0,    BUS_NONE, 64'h0,    4'd9,  BUS_NONE,  64'h0,    64'h0,    4'd0,  4'd0};
    vecs[5] = '{BUS_STORE, '1,       '1,       BUS_NONE, 64'h0,    4'd15, BUS_STORE, '1,       '1,       4'd15, 4'd0};
    vecs[6] = '{BUS_LOAD,  64'h6000, 64'hABCD, BUS_NONE, 64'h0,    4'd1,  BUS_LOAD,  64'h6000, 64'hABCD, 4'd1,  4'd0};
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].dc_cmd, vecs[i].dc_a, vecs[i].dc_d, vecs[i].ic_cmd, vecs[i].ic_a, vecs[i].rsp, 0, 0);
      check_bus($sformatf("vec%0d", i), vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_dcr, vecs[i].e_icr);
      tick();
    end
    do_reset();

    // ---------------- priority: dc wins the tie, ic goes next cycle
    drive(BUS_LOAD, 64'h100, 0, BUS_LOAD, 64'h200, 4'd3, 0, 0);
    check_bus("prio_c0", BUS_LOAD, 64'h100, 0, 4'd3, 4'd0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_LOAD, 64'h200, 4'd4, 0, 0);
    check_bus("prio_c1", BUS_LOAD, 64'h200, 0, 4'd0, 4'd4);
    tick();

    // ---------------- retry lock on ic while dc waits
    drive(BUS_NONE, 0, 0, BUS_LOAD, 64'h40, 4'd0, 0, 0);
    check_bus("lock_c0", BUS_LOAD, 64'h40, 0, 4'd0, 4'd0);
    tick();
    for (int i = 1; i < 3; i++) begin
      drive(BUS_LOAD, 64'h80, 0, BUS_LOAD, 64'h40, 4'd0, 0, 0);
      check_bus($sformatf("lock_c%0d", i), BUS_LOAD, 64'h40, 0, 4'd0, 4'd0);
      tick();
    end
    drive(BUS_LOAD, 64'h80, 0, BUS_LOAD, 64'h40, 4'd5, 0, 0);
    check_bus("lock_c3", BUS_LOAD, 64'h40, 0, 4'd0, 4'd5);
    tick();
    drive(BUS_LOAD, 64'h80, 0, BUS_NONE, 0, 4'd6, 0, 0);
    check_bus("lock_c4", BUS_LOAD, 64'h80, 0, 4'd6, 4'd0);
    tick();

    // ---------------- held requester drops: no issue, then back to IDLE
    drive(BUS_STORE, 64'h300, 64'h77, BUS_NONE, 0, 4'd0, 0, 0);
    check_bus("drop_c0", BUS_STORE, 64'h300, 64'h77, 4'd0, 4'd0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_LOAD, 64'h500, 4'd7, 0, 0);
    check_bus("drop_c1", BUS_NONE, 0, 0, 4'd0, 4'd0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_LOAD, 64'h500, 4'd7, 0, 0);
    check_bus("drop_c2", BUS_LOAD, 64'h500, 0, 4'd0, 4'd7);
    tick();
    do_reset();

    // ---------------- completion routing
    drive(BUS_NONE, 0, 0, BUS_LOAD, 64'h700, 4'd7, 0, 0);
    check_bus("route_ic", BUS_LOAD, 64'h700, 0, 4'd0, 4'd7);
    tick();
    drive(BUS_LOAD, 64'h800, 0, BUS_NONE, 0, 4'd2, 0, 0);
    check_bus("route_dc", BUS_LOAD, 64'h800, 0, 4'd2, 4'd0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd2, 64'h2222);
    check_ret("route_t2", 4'd2, 64'h2222, 4'd0, 0, 1'b0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd7, 64'h7777);
    check_ret("route_t7", 4'd0, 0, 4'd7, 64'h7777, 1'b0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd7, 64'h7778);
    check_ret("route_t7_again", 4'd0, 0, 4'd0, 0, 1'b1);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd0, 64'h1234);
    check_ret("route_t0", 4'd0, 0, 4'd0, 0, 1'b0);
    tick();

    // ---------------- clear/record collision on tag 4, then store orphan
    drive(BUS_LOAD, 64'h900, 0, BUS_NONE, 0, 4'd4, 0, 0);
    tick();
    drive(BUS_LOAD, 64'h940, 0, BUS_NONE, 0, 4'd4, 4'd4, 64'h44);
    check_bus("coll_issue", BUS_LOAD, 64'h940, 0, 4'd4, 4'd0);
    check_ret("coll_done", 4'd4, 64'h44, 4'd0, 0, 1'b0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd4, 64'h45);
    check_ret("coll_kept", 4'd4, 64'h45, 4'd0, 0, 1'b0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd4, 64'h46);
    check_ret("coll_gone", 4'd0, 0, 4'd0, 0, 1'b1);
    tick();
    drive(BUS_STORE, 64'hA00, 64'h99, BUS_NONE, 0, 4'd9, 0, 0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd9, 64'h1);
    check_ret("store_orphan", 4'd0, 0, 4'd0, 0, 1'b1);
    tick();

    // ---------------- second acceptance to a valid tag overwrites the owner
    drive(BUS_NONE, 0, 0, BUS_LOAD, 64'hB00, 4'd8, 0, 0);
    tick();
    drive(BUS_LOAD, 64'hC00, 0, BUS_NONE, 0, 4'd8, 0, 0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd8, 64'h88);
    check_ret("overwrite", 4'd8, 64'h88, 4'd0, 0, 1'b0);
    tick();

    // ---------------- async reset in HOLD_D, then pre-reset tag is an orphan
    drive(BUS_LOAD, 64'hD00, 0, BUS_NONE, 0, 4'd10, 0, 0);
    tick();
    drive(BUS_LOAD, 64'hE00, 0, BUS_NONE, 0, 4'd0, 0, 0);
    check_bus("hold_d", BUS_LOAD, 64'hE00, 0, 4'd0, 4'd0);
    tick();
    drive(BUS_LOAD, 64'hE00, 0, BUS_NONE, 0, 4'd3, 4'd10, 64'h10);
    check_ret("pre_rst", 4'd10, 64'h10, 4'd0, 0, 1'b0);
    reset = 1'b0;
    #1;
    check_bus("async_rst", BUS_NONE, 0, 0, 4'd0, 4'd0);
    check_ret("async_rst", 4'd0, 0, 4'd0, 0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    drive(BUS_NONE, 0, 0, BUS_LOAD, 64'hF00, 4'd2, 0, 0);
    check_bus("post_rst_idle", BUS_LOAD, 64'hF00, 0, 4'd0, 4'd2);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd10, 64'h10);
    check_ret("post_rst_orphan", 4'd0, 0, 4'd0, 0, 1'b1);
    tick();

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // ---------------- round robin: continuous tie alternates dc, ic, ...
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(BUS_LOAD, 64'h1000, 0, BUS_LOAD, 64'h2000, 4'd1, 0, 0);
      check($sformatf("rr_c%0d.addr", i), proc2mem_addr, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      tick();
    end
`endif

    // ---------------- randomized run against the reference model
    do_reset();
    foreach (owner_tab[t]) owner_tab[t] = -1;
    locked = -1;
    favour = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus_command_e dcc, icc, e_cmd;
      logic [63:0]  dca, dcd, ica, rd, e_addr, e_data, e_dcd, e_icd;
      logic [3:0]   rsp, tg, e_dcr, e_icr, e_dct, e_ict;
      logic         e_orph;
      int           win;

      dcc = bus_command_e'(2'($urandom_range(0, 2)));
      icc = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
      dca = {$urandom, $urandom};
      dcd = {$urandom, $urandom};
      ica = {$urandom, $urandom};
      rd  = {$urandom, $urandom};
      rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tg  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;

      // Who owns the bus this cycle.
      if (locked == 0)                              win = (dcc != BUS_NONE) ? 0 : -1;
      else if (locked == 1)                         win = (icc != BUS_NONE) ? 1 : -1;
      else if (dcc != BUS_NONE && icc != BUS_NONE)
`ifdef MEM_ARB_ROUND_ROBIN_EN
                                                    win = favour;
`else
                                                    win = 0;
`endif
      else if (dcc != BUS_NONE)                     win = 0;
      else if (icc != BUS_NONE)                     win = 1;
      else                                          win = -1;

      e_cmd  = (win == 0) ? dcc : (win == 1) ? icc : BUS_NONE;
      e_addr = (win == 0) ? dca : (win == 1) ? ica : 64'h0;
      e_data = (win == 0) ? dcd : 64'h0;
      e_dcr  = (win == 0) ? rsp : 4'd0;
      e_icr  = (win == 1) ? rsp : 4'd0;
      e_dct = 0; e_dcd = 0; e_ict = 0; e_icd = 0; e_orph = 1'b0;
      if (tg != 0) begin
        if (owner_tab[tg] == 0)      begin e_dct = tg; e_dcd = rd; end
        else if (owner_tab[tg] == 1) begin e_ict = tg; e_icd = rd; end
        else                         e_orph = 1'b1;
      end

      drive(dcc, dca, dcd, icc, ica, rsp, tg, rd);
      check_bus($sformatf("rnd%0d", cyc), e_cmd, e_addr, e_data, e_dcr, e_icr);
      check_ret($sformatf("rnd%0d", cyc), e_dct, e_dcd, e_ict, e_icd, e_orph);
      tick();

      // Advance the model: completion frees the tag, a new load claims it.
      if (tg != 0) owner_tab[tg] = -1;
      if (win >= 0 && rsp != 0) begin
        if (e_cmd == BUS_LOAD) owner_tab[rsp] = win;
        locked = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        favour = 1 - win;
`endif
      end else begin
        locked = win;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
